// File: rtl/perceptron_bp_pipe.sv
// Perceptron branch predictor with a registered prediction and an in-order
// tracking queue that trains on resolve, repairs the GHR and flushes on a mispredict.
module perceptron_bp_pipe #(
  parameter int GHR_WIDTH   = 16,
  parameter int TABLE_LOG2  = 5,
  parameter int WEIGHT_BITS = 8,
  parameter int THETA       = 44,
  parameter int INFLIGHT    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lookup_valid,
  output logic                        lookup_ready,
  input  logic [63:0]                 lookup_pc,
  output logic                        pred_valid,
  output logic                        pred_taken,
  output logic                        pred_low_conf,
  input  logic                        update_valid,
  input  logic                        update_taken,
  output logic                        flush,
  output logic [$clog2(INFLIGHT):0]   inflight_cnt,
  output logic                        err_underflow
);

  localparam int H       = GHR_WIDTH;
  localparam int W       = WEIGHT_BITS;
  localparam int ENTRIES = 1 << TABLE_LOG2;
  localparam int SW      = W + $clog2(H + 1) + 1;
  localparam int PW      = $clog2(INFLIGHT);
  localparam int CW      = PW + 1;

  typedef logic signed [W-1:0]  weight_t;
  typedef logic signed [SW-1:0] sum_t;

  localparam weight_t WMAX = weight_t'((1 << (W - 1)) - 1);
  localparam weight_t WMIN = weight_t'(-(1 << (W - 1)));

  weight_t               weights [ENTRIES][H+1];
  logic [H-1:0]          ghr;

  logic [TABLE_LOG2-1:0] q_idx   [INFLIGHT];
  logic [H-1:0]          q_ghr   [INFLIGHT];
  sum_t                  q_sum   [INFLIGHT];
  logic                  q_taken [INFLIGHT];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;

  logic [TABLE_LOG2-1:0] lk_idx;
  sum_t                  lk_sum;
  sum_t                  lk_abs;
  logic                  lk_taken;
  logic                  lk_low;

  logic [TABLE_LOG2-1:0] e_idx;
  logic [H-1:0]          e_ghr;
  sum_t                  e_sum;
  sum_t                  e_abs;
  logic                  e_taken;

  logic                  accept;
  logic                  pop;
  logic                  mis;
  logic                  push;
  logic                  train;
  logic                  underflow;
  weight_t               new_w [H+1];

  logic                  unused_pc;

  function automatic weight_t sat_step(weight_t w, logic up);
    if (up) return (w == WMAX) ? w : w + weight_t'(1);
    else    return (w == WMIN) ? w : w - weight_t'(1);
  endfunction

  assign lk_idx    = lookup_pc[TABLE_LOG2+1:2];
  assign unused_pc = ^{lookup_pc[63:TABLE_LOG2+2], lookup_pc[1:0]};

  // Dot product of the indexed weights with the +/-1 history vector, bias first.
  always_comb begin
    lk_sum = sum_t'(weights[lk_idx][0]);
    for (int i = 1; i <= H; i++) begin
      if (ghr[i-1]) lk_sum = lk_sum + sum_t'(weights[lk_idx][i]);
      else          lk_sum = lk_sum - sum_t'(weights[lk_idx][i]);
    end
  end

  assign lk_abs   = lk_sum[SW-1] ? -lk_sum : lk_sum;
  assign lk_taken = ~lk_sum[SW-1];
  assign lk_low   = (lk_abs <= sum_t'(THETA));

  assign e_idx   = q_idx[rd_ptr];
  assign e_ghr   = q_ghr[rd_ptr];
  assign e_sum   = q_sum[rd_ptr];
  assign e_taken = q_taken[rd_ptr];
  assign e_abs   = e_sum[SW-1] ? -e_sum : e_sum;

  assign lookup_ready = (inflight_cnt < CW'(INFLIGHT));
  assign accept       = lookup_valid && lookup_ready;
  assign pop          = update_valid && (inflight_cnt != '0);
  assign underflow    = update_valid && (inflight_cnt == '0);
  assign mis          = pop && (e_taken != update_taken);
  assign push         = accept && !mis;
  assign train        = pop && (mis || (e_abs <= sum_t'(THETA)));

  // Trained weights for the popped entry; written back only when train is set.
  always_comb begin
    new_w[0] = sat_step(weights[e_idx][0], update_taken);
    for (int i = 1; i <= H; i++) begin
      new_w[i] = sat_step(weights[e_idx][i], update_taken == e_ghr[i-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < ENTRIES; e++) begin
        for (int i = 0; i <= H; i++) begin
          weights[e][i] <= '0;
        end
      end
      ghr           <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      inflight_cnt  <= '0;
      pred_valid    <= 1'b0;
      pred_taken    <= 1'b0;
      pred_low_conf <= 1'b0;
      flush         <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      flush      <= mis;
      pred_valid <= push;
      if (push) begin
        pred_taken    <= lk_taken;
        pred_low_conf <= lk_low;
      end
      if (underflow) err_underflow <= 1'b1;
      if (train) begin
        for (int i = 0; i <= H; i++) begin
          weights[e_idx][i] <= new_w[i];
        end
      end
      // A mispredict rebuilds history from the snapshot and drops every younger lookup.
      if (mis) begin
        ghr          <= {e_ghr[H-2:0], update_taken};
        rd_ptr       <= '0;
        wr_ptr       <= '0;
        inflight_cnt <= '0;
      end else begin
        if (push) ghr <= {ghr[H-2:0], lk_taken};
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        inflight_cnt <= inflight_cnt + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr]   <= lk_idx;
      q_ghr[wr_ptr]   <= ghr;
      q_sum[wr_ptr]   <= lk_sum;
      q_taken[wr_ptr] <= lk_taken;
    end
  end

endmodule
